// File: rtl/bnn_image_loader.sv
// Byte-wide MNIST image loader: packs 98 valid-strobed bytes into the 784-bit pixel vector for layer_one.
// Optional trailing XOR checksum byte enabled by defining BNN_LOADER_CHECKSUM_EN.
module bnn_image_loader #(
    parameter int unsigned N_BYTES    = 98,
    parameter logic [2:0]  LOAD_STATE = 3'd1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             state,
    input  logic                   frame_start,
    input  logic                   data_valid,
    input  logic [7:0]             data_in,
    output logic [8*N_BYTES-1:0]   pixels,
    output logic                   load_done,
    output logic                   busy,
    output logic                   frame_err
);

    localparam int unsigned PIX_W = 8 * N_BYTES;
    localparam int unsigned CNT_W = 7;
    localparam int unsigned IDX_W = $clog2(PIX_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } fsm_t;

    fsm_t             r_fsm;
    logic [CNT_W-1:0] r_cnt;
    logic [PIX_W-1:0] r_pixels;
    logic             r_load_done;
    logic             r_busy;

    logic             w_in_load;
    logic             w_last;
    logic [IDX_W-1:0] w_bit_idx;

    assign w_in_load = (state == LOAD_STATE);
    assign w_last    = (r_cnt == CNT_W'(N_BYTES - 1));
    assign w_bit_idx = IDX_W'({r_cnt, 3'b000});

`ifdef BNN_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_frame_err;
    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

    assign pixels    = r_pixels;
    assign load_done = r_load_done;
    assign busy      = r_busy;

    // Loader FSM; frame restarts clear pixels/count/sum/error and may take byte 0 in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm       <= S_IDLE;
            r_cnt       <= '0;
            r_pixels    <= '0;
            r_load_done <= 1'b0;
            r_busy      <= 1'b0;
`ifdef BNN_LOADER_CHECKSUM_EN
            r_sum       <= '0;
            r_frame_err <= 1'b0;
`endif
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (frame_start && w_in_load) begin
                        r_pixels <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_fsm    <= S_LOAD;
`ifdef BNN_LOADER_CHECKSUM_EN
                        r_sum       <= '0;
                        r_frame_err <= 1'b0;
`endif
                    end
                end

                S_LOAD, S_CHECK: begin
                    if (!w_in_load) begin
                        r_busy <= 1'b0;
                        r_fsm  <= S_IDLE;
                    end else if (frame_start) begin
                        r_pixels <= '0;
                        r_cnt    <= '0;
                        r_fsm    <= S_LOAD;
`ifdef BNN_LOADER_CHECKSUM_EN
                        r_sum       <= '0;
                        r_frame_err <= 1'b0;
`endif
                        if (data_valid) begin
                            r_pixels[7:0] <= data_in;
                            r_cnt         <= CNT_W'(1);
`ifdef BNN_LOADER_CHECKSUM_EN
                            r_sum         <= data_in;
`endif
                        end
                    end else if (data_valid) begin
`ifdef BNN_LOADER_CHECKSUM_EN
                        if (r_fsm == S_CHECK) begin
                            r_busy <= 1'b0;
                            if (data_in == r_sum) begin
                                r_load_done <= 1'b1;
                                r_fsm       <= S_DONE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_fsm       <= S_IDLE;
                            end
                        end else begin
`endif
                            r_pixels[w_bit_idx +: 8] <= data_in;
                            r_cnt                    <= r_cnt + CNT_W'(1);
`ifdef BNN_LOADER_CHECKSUM_EN
                            r_sum                    <= r_sum ^ data_in;
                            if (w_last) begin
                                r_fsm <= S_CHECK;
                            end
`else
                            if (w_last) begin
                                r_load_done <= 1'b1;
                                r_busy      <= 1'b0;
                                r_fsm       <= S_DONE;
                            end
`endif
`ifdef BNN_LOADER_CHECKSUM_EN
                        end
`endif
                    end
                end

                S_DONE: begin
                    if (!w_in_load) begin
                        r_load_done <= 1'b0;
                        r_fsm       <= S_IDLE;
                    end else if (frame_start) begin
                        r_pixels    <= '0;
                        r_cnt       <= '0;
                        r_load_done <= 1'b0;
                        r_busy      <= 1'b1;
                        r_fsm       <= S_LOAD;
`ifdef BNN_LOADER_CHECKSUM_EN
                        r_sum       <= '0;
                        r_frame_err <= 1'b0;
`endif
                    end
                end

                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_image_loader.sv
// Scoreboard bench for bnn_image_loader: stimulus queues expected frames, a negedge monitor checks each completion.
module tb_bnn_image_loader;

    localparam int unsigned N = 98;

    logic         clk;
    logic         reset;
    logic [2:0]   state;
    logic         frame_start;
    logic         data_valid;
    logic [7:0]   data_in;
    logic [783:0] pixels;
    logic         load_done;
    logic         busy;
    logic         frame_err;

    typedef struct {
        logic [783:0] pix;
        logic         err;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] fb[N];
    int         n_vec;
    int         n_err;
    logic       prev_done;
    logic       prev_err;

    bnn_image_loader dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .frame_start (frame_start),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .pixels      (pixels),
        .load_done   (load_done),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tally(input string nm, input bit ok, input string got, input string want);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %s expected %s", nm, got, want);
        end
    endtask

    task automatic check_bit(input string nm, input logic a, input logic e);
        tally(nm, a === e, $sformatf("%b", a), $sformatf("%b", e));
    endtask

    task automatic check_byte(input string nm, input logic [7:0] a, input logic [7:0] e);
        tally(nm, a === e, $sformatf("%h", a), $sformatf("%h", e));
    endtask

    task automatic check_pix(input string nm, input logic [783:0] a, input logic [783:0] e);
        tally(nm, a === e, $sformatf("%h", a), $sformatf("%h", e));
    endtask

    function automatic logic [783:0] pack_fb(input int nbytes);
        logic [783:0] p;
        p = '0;
        for (int i = 0; i < nbytes; i++) p[8*i +: 8] = fb[i];
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_valid = 1'b1;
        data_in    = b;
        step();
        data_valid = 1'b0;
    endtask

    // Full frame from fb[], optional idle cycle before every byte, optional corrupted checksum
    task automatic run_frame(input bit stall, input bit bad_cs);
        logic [7:0] x;
        x = 8'h00;
        state       = 3'd1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check_bit("busy_rise", busy, 1'b1);
        sb_q.push_back('{pack_fb(N), bad_cs});
        for (int i = 0; i < int'(N); i++) begin
            if (stall) step();
            if (i == int'(N) - 1) check_bit("done_before_last", load_done, 1'b0);
            send_byte(fb[i]);
            x ^= fb[i];
        end
`ifdef BNN_LOADER_CHECKSUM_EN
        check_bit("done_before_cs", load_done, 1'b0);
        send_byte(x ^ {7'b0, bad_cs});
`endif
        check_bit("done_at_last", load_done, ~bad_cs);
        check_bit("busy_end", busy, 1'b0);
    endtask

    // Monitor: any rising load_done or frame_err is a frame completion
    initial begin
        prev_done = 1'b0;
        prev_err  = 1'b0;
        forever begin
            @(negedge clk);
            if ((load_done && !prev_done) || (frame_err && !prev_err)) begin
                if (sb_q.size() == 0) begin
                    tally("unexpected_completion", 1'b0, $sformatf("done=%b err=%b", load_done, frame_err), "no completion");
                end else begin
                    mon_e = sb_q.pop_front();
                    check_pix("frame_pixels", pixels, mon_e.pix);
                    check_bit("frame_err", frame_err, mon_e.err);
                    check_bit("frame_done", load_done, ~mon_e.err);
                end
            end
            prev_done = load_done;
            prev_err  = frame_err;
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: got no end of test expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [783:0] p;
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b1;
        state       = 3'd1;
        frame_start = 1'b1;
        data_valid  = 1'b1;
        data_in     = 8'hA5;
        step();
        step();
        reset       = 1'b0;
        frame_start = 1'b0;
        data_valid  = 1'b0;
        check_pix("rst_pixels", pixels, '0);
        check_bit("rst_done", load_done, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_err", frame_err, 1'b0);

        // Basic load with index-valued bytes
        for (int i = 0; i < int'(N); i++) fb[i] = 8'(i);
        run_frame(1'b0, 1'b0);
        check_byte("basic_byte1", pixels[15:8], 8'h01);
        check_byte("basic_byte97", pixels[783:776], 8'h61);
        send_byte(8'hEE);
        check_pix("done_ignores_data", pixels, pack_fb(N));
        check_bit("done_held", load_done, 1'b1);
        state = 3'd2;
        step();
        check_bit("done_fall", load_done, 1'b0);

        // Same frame with a stall before every byte
        run_frame(1'b1, 1'b0);
        state = 3'd2;
        step();

        // Restart after 40 bytes of 0xFF, new byte 0 taken with frame_start
        state       = 3'd1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 40; i++) send_byte(8'hFF);
        for (int i = 0; i < int'(N); i++) fb[i] = 8'h00;
        fb[0] = 8'h5A;
        sb_q.push_back('{pack_fb(N), 1'b0});
        frame_start = 1'b1;
        send_byte(8'h5A);
        frame_start = 1'b0;
        check_bit("restart_busy", busy, 1'b1);
        for (int i = 1; i < int'(N); i++) send_byte(8'h00);
`ifdef BNN_LOADER_CHECKSUM_EN
        send_byte(8'h5A);
`endif
        check_bit("restart_done", load_done, 1'b1);
        check_byte("restart_byte0", pixels[7:0], 8'h5A);
        state = 3'd2;
        step();

        // Abort after 50 bytes by leaving the load state
        for (int i = 0; i < int'(N); i++) fb[i] = 8'(i);
        state       = 3'd1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 50; i++) send_byte(fb[i]);
        state = 3'd0;
        step();
        p = pack_fb(50);
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", load_done, 1'b0);
        check_pix("abort_partial", pixels, p);
        state = 3'd1;
        for (int i = 0; i < 3; i++) send_byte(8'hAA);
        check_pix("abort_no_write", pixels, p);
        check_bit("abort_idle_busy", busy, 1'b0);
        check_bit("abort_err", frame_err, 1'b0);

        // Reset after 10 bytes, then a clean frame
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 10; i++) send_byte(8'hC3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_pix("midrst_pixels", pixels, '0);
        check_bit("midrst_done", load_done, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_err", frame_err, 1'b0);
        for (int i = 0; i < int'(N); i++) fb[i] = 8'(i * 3 + 7);
        run_frame(1'b0, 1'b0);
        state = 3'd2;
        step();

`ifdef BNN_LOADER_CHECKSUM_EN
        // Good then bad checksum on a frame of 0x01 bytes
        for (int i = 0; i < int'(N); i++) fb[i] = 8'h01;
        run_frame(1'b0, 1'b0);
        check_bit("cs_good_err", frame_err, 1'b0);
        state = 3'd2;
        step();
        run_frame(1'b0, 1'b1);
        check_bit("cs_bad_err", frame_err, 1'b1);
        send_byte(8'h00);
        check_bit("cs_bad_idle_done", load_done, 1'b0);
        check_bit("cs_bad_idle_busy", busy, 1'b0);
        check_bit("cs_bad_err_sticky", frame_err, 1'b1);
`endif

        step();
        step();
        check_bit("scoreboard_drained", sb_q.size() == 0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bnn_image_loader.md
# bnn_image_loader

Byte-wide image loader for the MNIST BNN, sitting directly upstream of `layer_one`. It accepts the 784-pixel binarized image as 98 bytes on a valid strobe, packs them into the 784-bit `pixels` vector, and raises `load_done` so the top FSM can leave the load state. It replaces the one-bit-per-cycle pixel path and cuts image load time by 8x. An optional checksum byte guards the frame.

## Interface
- `N_BYTES`, 98: data bytes per frame (784 / 8).
- `LOAD_STATE`, 3'd1: top-FSM `state` code during which loading is permitted.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `state` input 3: current top-FSM state.
- `frame_start` input 1: single-cycle pulse that begins a new frame.
- `data_valid` input 1: `data_in` carries a byte this cycle.
- `data_in` input 8: pixel byte; bit 0 is the lowest-numbered pixel.
- `pixels` output 784: packed image to `layer_one`.
- `load_done` output 1: full frame accepted (level).
- `busy` output 1: frame in progress.
- `frame_err` output 1: checksum mismatch on the last frame (sticky until next `frame_start`).

## Operation
- Internal FSM states: IDLE, LOAD, CHECK (only with checksum), DONE. A 7-bit byte counter `cnt` and an 8-bit running XOR `sum` support the FSM.
- IDLE: `frame_start` while `state == LOAD_STATE` clears `pixels`, `cnt`, `sum` and `frame_err`, then goes to LOAD. `frame_start` at any other `state` value is ignored.
- LOAD: each cycle with `data_valid` high writes `data_in` into `pixels[8*cnt+7 : 8*cnt]`, XORs it into `sum`, and increments `cnt`.
  - On the byte with `cnt == N_BYTES-1`, the FSM goes to DONE, or to CHECK if checksum is enabled.
  - Cycles with `data_valid` low are stalls and change nothing.
- CHECK: the next valid byte is compared against `sum`.
  - Equal: go to DONE.
  - Not equal: set `frame_err`, go to IDLE, keep `load_done` low.
- DONE: `load_done` is held high until `state != LOAD_STATE`, then the FSM returns to IDLE. `pixels` is held unchanged and `data_valid` is ignored.
- `busy` is high in LOAD and CHECK.
- `frame_start` in LOAD or CHECK restarts the frame: clear, go to LOAD. A `data_valid` byte in the same cycle is accepted as byte 0.
- `state` leaving `LOAD_STATE` while in LOAD or CHECK aborts to IDLE. `pixels` keeps the partial data, `load_done` stays low, `frame_err` is unchanged.
- `frame_start` while in DONE with `state == LOAD_STATE`: behaves as from IDLE (restart).
- Bytes beyond the frame are never written. `cnt` never exceeds `N_BYTES`; there is no wrap-around.

## Timing
- Reset values: `pixels` = 0, `load_done` = 0, `busy` = 0, `frame_err` = 0; FSM in IDLE, `cnt` = 0, `sum` = 0. Reset overrides all other inputs in the same cycle.
- `busy` rises the cycle after `frame_start`.
- A byte accepted on edge k is visible in `pixels` after edge k.
- `load_done` rises on the edge that accepts the final byte: byte 97, or the checksum byte when enabled. It is therefore visible in the same cycle as the final `pixels` update. The minimum frame takes 98 (or 99) consecutive valid cycles.
- `load_done` falls on the first edge after `state != LOAD_STATE` is sampled.
- `frame_err` rises on the edge that accepts a bad checksum byte.

## Configuration
- `BNN_LOADER_CHECKSUM_EN` defined: the CHECK state exists, a 99th byte equal to the XOR of the 98 data bytes is required, and `frame_err` is live.
- Not defined: LOAD goes straight to DONE after byte 97, `sum` logic is removed, and `frame_err` is tied to 0.

## Test plan
- Basic load: reset; `state=1`; `frame_start`; 98 valid bytes with value equal to their index (0x00..0x61) -> `pixels[15:8]=0x01`, `pixels[783:776]=0x61`, `load_done=1` after byte 97; drop `state` to 2 -> `load_done=0` next cycle.
- Stalls: same frame with `data_valid` low on every other cycle -> identical `pixels`; `load_done` rises on the edge accepting byte 97.
- Restart: after 40 bytes of 0xFF, `frame_start` together with a valid byte 0x5A, then 97 bytes of 0x00 -> `pixels[7:0]=0x5A`, all other bits 0, `load_done=1`.
- Abort: `state` changes 1->0 after 50 bytes -> IDLE, `busy=0`, `load_done` never asserted; further `data_valid` leaves `pixels` unchanged.
- Checksum (with `BNN_LOADER_CHECKSUM_EN`): 98 bytes of 0x01, checksum 0x00 -> `load_done=1`, `frame_err=0`; repeat with checksum 0x01 -> `frame_err=1`, `load_done=0`, FSM in IDLE.
- Reset mid-frame: `reset` high after 10 bytes -> all outputs 0 on the next edge; a new frame then loads correctly.
